// File: rtl/pq_pkg.sv
// pq_pkg - shared types for the hardware priority queue and its clients.
//   kv_t : packed {key, val}; the queue orders items by key only.
package pq_pkg;

   localparam int KEY_W = 16;
   localparam int VAL_W = 16;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

endpackage

// File: rtl/pq_if.sv
// pq_if - connection bundle between a priority queue and one client.
//   ivalid/irdy/idata : insert stream (client -> queue), completes on ivalid&irdy
//   busy              : queue is still reorganising after an insert/remove
//   full              : queue cannot take another item
//   ovalid/ordy/odata : head of the queue, removed on ovalid&ordy
interface pq_if;

   logic          ivalid;
   logic          irdy;
   pq_pkg::kv_t   idata;
   logic          busy;
   logic          full;
   logic          ovalid;
   logic          ordy;
   pq_pkg::kv_t   odata;

   modport client (
      output ivalid, idata, ordy,
      input  irdy, busy, full, ovalid, odata
   );

   modport server (
      input  ivalid, idata, ordy,
      output irdy, busy, full, ovalid, odata
   );

endinterface

// File: rtl/pq_batch_sorter.sv
// pq_batch_sorter - batch front end for the hardware priority queue.
//   Collects one batch from the input stream into the queue, waits for the
//   queue to settle, then drains the same number of items back out in priority
//   order with m_last on the final one. Output ordering and queue underflow are
//   monitored and reported through sticky flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data   input item stream, s_last closes the batch
//   m_valid/m_ready/m_data   output item stream, m_last marks the final item
//   pq                       client side of the priority queue
//   batch_cnt                items inserted in the current or last batch
//   trunc                    sticky: batch force-closed at MAX_BATCH
//   order_err                sticky: output key broke the MIN_FIRST ordering
//   underflow_err            sticky: queue ran dry while items were still owed
module pq_batch_sorter
   import pq_pkg::*;
#(
   parameter int MAX_BATCH = 16,
   parameter bit MIN_FIRST = 1'b1,
   parameter int CNT_W     = $clog2(MAX_BATCH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  kv_t              s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output kv_t              m_data,
   output logic             m_last,
   pq_if.client             pq,
   output logic [CNT_W-1:0] batch_cnt,
   output logic             trunc,
   output logic             order_err,
   output logic             underflow_err
);

   typedef enum logic [1:0] {IDLE, FILL, SETTLE, DRAIN} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BATCH);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] remaining;
   logic [KEY_W-1:0] last_key;
   logic             in_xfer;
   logic             out_xfer;
   logic             starved;
   logic             at_max;

   // True when key breaks the configured ordering relative to the previous key.
   // Equal keys are always acceptable.
   function automatic logic out_of_order(input logic [KEY_W-1:0] key,
                                         input logic [KEY_W-1:0] prev);
      if (MIN_FIRST)
         return key < prev;
      else
         return key > prev;
   endfunction

   assign at_max = (batch_cnt + ONE) == MAX_CNT;

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      pq.ivalid = 1'b0;
      pq.idata  = s_data;
      pq.ordy   = 1'b0;
      m_valid   = 1'b0;
      m_data    = pq.odata;
      m_last    = 1'b0;
      in_xfer   = 1'b0;
      out_xfer  = 1'b0;
      starved   = 1'b0;
      case (state)
         IDLE: begin
            if (s_valid)
               state_nxt = FILL;
         end
         FILL: begin
            s_ready   = pq.irdy & ~pq.full & (batch_cnt < MAX_CNT);
            in_xfer   = s_valid & pq.irdy & ~pq.full & (batch_cnt < MAX_CNT);
            pq.ivalid = in_xfer;
            // A full batch closes even without s_last; the rest of the
            // producer's items start a fresh batch.
            if (in_xfer && (s_last || at_max))
               state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!pq.busy)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            m_valid  = pq.ovalid & (remaining != '0);
            out_xfer = pq.ovalid & (remaining != '0) & m_ready;
            pq.ordy  = out_xfer;
            m_last   = pq.ovalid & (remaining == ONE);
            // An idle queue with no head means items were lost.
            starved  = ~pq.ovalid & ~pq.busy & (remaining != '0);
            if ((out_xfer && remaining == ONE) || starved)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         batch_cnt     <= '0;
         remaining     <= '0;
         trunc         <= 1'b0;
         order_err     <= 1'b0;
         underflow_err <= 1'b0;
         last_key      <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (s_valid)
                  batch_cnt <= '0;
            end
            FILL: begin
               if (in_xfer) begin
                  batch_cnt <= batch_cnt + ONE;
                  if (at_max && !s_last)
                     trunc <= 1'b1;
               end
            end
            SETTLE: begin
               remaining <= batch_cnt;
            end
            DRAIN: begin
               if (out_xfer) begin
                  remaining <= remaining - ONE;
                  last_key  <= m_data.key;
                  // remaining still equals batch_cnt only on the first item,
                  // which has no predecessor to compare against.
                  if (remaining != batch_cnt && out_of_order(m_data.key, last_key))
                     order_err <= 1'b1;
               end else if (starved) begin
                  underflow_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_batch_sorter.sv
// tb_pq_batch_sorter - directed bench for pq_batch_sorter.
//   A behavioural queue sits on the pq port. In sorted mode it holds up to 16
//   items, presents the smallest key and stays busy for two cycles after each
//   insert. In script mode it ignores inserts and presents a fixed sequence of
//   heads so ordering and underflow faults can be provoked.
module tb_pq_batch_sorter;
   import pq_pkg::*;

   localparam int CAP = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   kv_t        s_data = '0;
   logic       s_last = 1'b0;
   logic       m_valid;
   logic       m_ready = 1'b0;
   kv_t        m_data;
   logic       m_last;
   logic [4:0] batch_cnt;
   logic       trunc;
   logic       order_err;
   logic       underflow_err;

   pq_if pq_bus();

   pq_batch_sorter #(.MAX_BATCH(16), .MIN_FIRST(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .pq           (pq_bus),
      .batch_cnt    (batch_cnt),
      .trunc        (trunc),
      .order_err    (order_err),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural priority queue ----------------
   kv_t  mem [CAP];
   int   cnt = 0;
   int   busy_cnt = 0;
   int   min_idx;
   logic script_mode = 1'b0;
   kv_t  script [8];
   int   script_len = 0;
   int   script_idx = 0;

   always_comb begin
      min_idx = 0;
      for (int i = 1; i < CAP; i++)
         if (i < cnt && mem[i].key < mem[min_idx].key)
            min_idx = i;
      pq_bus.irdy = 1'b1;
      pq_bus.full = (cnt >= CAP);
      if (script_mode) begin
         pq_bus.busy   = 1'b0;
         pq_bus.ovalid = (script_idx < script_len);
         pq_bus.odata  = script[script_idx % 8];
      end else begin
         pq_bus.busy   = (busy_cnt != 0);
         pq_bus.ovalid = (cnt != 0) && (busy_cnt == 0);
         pq_bus.odata  = mem[min_idx];
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         cnt        <= 0;
         busy_cnt   <= 0;
         script_idx <= 0;
      end else begin
         if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
         if (pq_bus.ivalid && pq_bus.irdy && !script_mode && cnt < CAP) begin
            mem[cnt] <= pq_bus.idata;
            cnt      <= cnt + 1;
            busy_cnt <= 2;
         end
         if (pq_bus.ovalid && pq_bus.ordy) begin
            if (script_mode)
               script_idx <= script_idx + 1;
            else begin
               mem[min_idx] <= mem[cnt-1];
               cnt          <= cnt - 1;
            end
         end
      end
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, no handshake seen, one required", name);
   endtask

   // The queue must never be offered an item while it reports full.
   always @(negedge clk) begin
      if (!rst && pq_bus.ivalid) begin
         n_checks++;
         if (pq_bus.full) begin
            n_fail++;
            $display("FAIL ivalid_while_full: got ivalid=1 full=1, expected no insert");
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   kv_t         src [32];
   logic        src_last [32];
   int          src_n;
   logic [15:0] got_key [32];
   logic        got_last [32];
   logic        oerr_snap [32];
   int          got_n;

   task automatic send_batch();
      for (int i = 0; i < src_n; i++) begin
         int guard;
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = src[i];
         s_last  = src_last[i];
         guard   = 0;
         while (!s_ready && guard < 400) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 400) begin
            bound_fail("send_item");
            break;
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic collect(input int n, input bit toggle);
      int   guard   = 0;
      logic stalled = 1'b0;
      logic pend    = 1'b0;
      logic rdy     = 1'b0;
      int   pidx    = 0;
      kv_t  held    = '0;
      got_n = 0;
      while (got_n < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (pend) begin
            oerr_snap[pidx] = order_err;
            pend = 1'b0;
         end
         if (stalled && m_valid)
            check("stall_hold", m_data, held);
         rdy     = toggle ? ~rdy : 1'b1;
         m_ready = rdy;
         if (m_valid && m_ready) begin
            got_key[got_n]  = m_data.key;
            got_last[got_n] = m_last;
            pidx  = got_n;
            pend  = 1'b1;
            got_n++;
         end
         stalled = m_valid && !m_ready;
         held    = m_data;
      end
      if (got_n < n)
         bound_fail("collect_items");
      @(negedge clk);
      if (pend)
         oerr_snap[pidx] = order_err;
      m_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          n;
      logic [15:0] keys [20];
      bit          toggle;
      logic [15:0] exp_keys [20];
      int          exp_cnt;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, test incomplete");
      $fatal(1, "watchdog");
   end

   initial begin
      // batch of 4, free-running output
      vecs[0].n = 4; vecs[0].toggle = 1'b0; vecs[0].exp_cnt = 4;
      vecs[0].keys[0] = 9; vecs[0].keys[1] = 3; vecs[0].keys[2] = 7; vecs[0].keys[3] = 1;
      vecs[0].exp_keys[0] = 1; vecs[0].exp_keys[1] = 3; vecs[0].exp_keys[2] = 7; vecs[0].exp_keys[3] = 9;
      // duplicate keys with a stalling consumer
      vecs[1].n = 5; vecs[1].toggle = 1'b1; vecs[1].exp_cnt = 5;
      vecs[1].keys[0] = 4; vecs[1].keys[1] = 4; vecs[1].keys[2] = 2; vecs[1].keys[3] = 4; vecs[1].keys[4] = 2;
      vecs[1].exp_keys[0] = 2; vecs[1].exp_keys[1] = 2; vecs[1].exp_keys[2] = 4; vecs[1].exp_keys[3] = 4;
      vecs[1].exp_keys[4] = 4;
      // single-item batch
      vecs[2].n = 1; vecs[2].toggle = 1'b0; vecs[2].exp_cnt = 1;
      vecs[2].keys[0] = 42; vecs[2].exp_keys[0] = 42;
      // exactly MAX_BATCH items closed by s_last: no truncation
      vecs[3].n = 16; vecs[3].toggle = 1'b1; vecs[3].exp_cnt = 16;
      for (int i = 0; i < 16; i++) begin
         vecs[3].keys[i]     = 16'(16 - i);
         vecs[3].exp_keys[i] = 16'(1 + i);
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_ivalid", pq_bus.ivalid, 0);
      check("rst_ordy", pq_bus.ordy, 0);
      check("rst_batch_cnt", batch_cnt, 0);
      check("rst_flags", {trunc, order_err, underflow_err}, 0);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         src_n = vecs[v].n;
         for (int i = 0; i < src_n; i++) begin
            src[i].key  = vecs[v].keys[i];
            src[i].val  = 16'(i);
            src_last[i] = (i == src_n - 1);
         end
         fork
            send_batch();
            collect(vecs[v].n, vecs[v].toggle);
         join
         for (int i = 0; i < vecs[v].n; i++) begin
            check($sformatf("v%0d_key%0d", v, i), got_key[i], vecs[v].exp_keys[i]);
            check($sformatf("v%0d_last%0d", v, i), got_last[i], (i == vecs[v].n - 1));
         end
         check($sformatf("v%0d_batch_cnt", v), batch_cnt, vecs[v].exp_cnt);
         check($sformatf("v%0d_flags", v), {trunc, order_err, underflow_err}, 0);
      end

      // 20 items with s_last on the 20th: first 16 form a truncated batch
      src_n = 20;
      for (int i = 0; i < 20; i++) begin
         src[i].key  = 16'(100 - i);
         src[i].val  = 16'(i);
         src_last[i] = (i == 19);
      end
      fork
         send_batch();
         collect(20, 1'b0);
      join
      for (int i = 0; i < 20; i++) begin
         check($sformatf("trunc_key%0d", i), got_key[i], (i < 16) ? 85 + i : 81 + (i - 16));
         check($sformatf("trunc_last%0d", i), got_last[i], (i == 15 || i == 19));
      end
      check("trunc_flag", trunc, 1);
      check("trunc_batch2_cnt", batch_cnt, 4);

      // scripted heads 1,5,3: ordering fault on the third output
      do_reset();
      script_mode = 1'b1;
      script[0] = '{key: 16'd1, val: 16'd0};
      script[1] = '{key: 16'd5, val: 16'd1};
      script[2] = '{key: 16'd3, val: 16'd2};
      script_len = 3;
      src_n = 3;
      for (int i = 0; i < 3; i++) begin
         src[i].key  = 16'(20 + i);
         src[i].val  = '0;
         src_last[i] = (i == 2);
      end
      fork
         send_batch();
         collect(3, 1'b0);
      join
      check("ord_key0", got_key[0], 1);
      check("ord_key2", got_key[2], 3);
      check("ord_last2", got_last[2], 1);
      check("ord_err_after1", oerr_snap[0], 0);
      check("ord_err_after2", oerr_snap[1], 0);
      check("ord_err_after3", oerr_snap[2], 1);
      repeat (3) @(negedge clk);
      check("ord_err_sticky", order_err, 1);

      // scripted queue runs dry with two items still owed
      do_reset();
      script[0]  = '{key: 16'd10, val: 16'd0};
      script_len = 1;
      fork
         send_batch();
         collect(1, 1'b0);
      join
      @(negedge clk);
      check("uf_key0", got_key[0], 10);
      check("uf_last0", got_last[0], 0);
      check("uf_flag", underflow_err, 1);
      check("uf_m_valid", m_valid, 0);
      check("uf_order_err", order_err, 0);
      // a following batch must be accepted from IDLE
      script_mode = 1'b0;
      src_n = 1;
      src[0] = '{key: 16'd77, val: 16'd0};
      src_last[0] = 1'b1;
      fork
         send_batch();
         collect(1, 1'b0);
      join
      check("uf_next_key", got_key[0], 77);
      check("uf_next_last", got_last[0], 1);
      check("uf_sticky", underflow_err, 1);

      // reset in the middle of a drain
      src_n = 4;
      src[0].key = 16'd9; src[1].key = 16'd3; src[2].key = 16'd7; src[3].key = 16'd1;
      for (int i = 0; i < 4; i++) begin
         src[i].val  = '0;
         src_last[i] = (i == 3);
      end
      fork
         send_batch();
         collect(2, 1'b0);
      join
      check("mid_m_valid", m_valid, 1);
      check("mid_head", m_data.key, 7);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_s_ready", s_ready, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_m_last", m_last, 0);
      check("mid_rst_ordy", pq_bus.ordy, 0);
      check("mid_rst_ivalid", pq_bus.ivalid, 0);
      check("mid_rst_batch_cnt", batch_cnt, 0);
      check("mid_rst_flags", {trunc, order_err, underflow_err}, 0);
      rst = 1'b0;
      src_n = 1;
      src[0] = '{key: 16'd55, val: 16'd3};
      src_last[0] = 1'b1;
      fork
         send_batch();
         collect(1, 1'b0);
      join
      check("post_rst_key", got_key[0], 55);
      check("post_rst_last", got_last[0], 1);
      check("post_rst_batch_cnt", batch_cnt, 1);
      check("post_rst_flags", {trunc, order_err, underflow_err}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
